// File: rtl/mac_pkg.sv
// Shared definitions for the mac_dot_pipe multiply-accumulate pipeline.
// Holds the default widths, the S1 control payload type and the saturating add
// that the accumulator stage uses.
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 4;
    localparam int ACC_W_DEF  = 40;
    localparam int LEN_W_DEF  = 8;

    // Working width of sat_add. Any ACC_W up to SAT_W-1 fits, so a sum of two
    // ACC_W-bit operands never wraps inside the (SAT_W+1)-bit adder.
    localparam int SAT_W = 64;
    localparam logic signed [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

    // Control fields that travel with each beat through S1 and S2.
    typedef struct packed {
        logic last;
        logic first;
        logic mode;
    } s1_ctrl_t;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of acc_w bits, flagging when the clamp was applied.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int unsigned             acc_w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_res_t              r;
        sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi    = (SAT_ONE <<< (acc_w - 32'd1)) - SAT_ONE;
        lo    = -hi - SAT_ONE;
        r.ovf = 1'b0;
        r.val = sum[SAT_W-1:0];
        if (sum > hi) begin
            r.val = hi[SAT_W-1:0];
            r.ovf = 1'b1;
        end else if (sum < lo) begin
            r.val = lo[SAT_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_dot_pipe_adder_tree.sv
// mac_adder_tree: registered reduction of LANES signed inputs into one sum.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          load the new sum (held otherwise)
//   in_data     LANES packed signed values, lane i at [i*IN_W +: IN_W]
//   sum         registered signed sum, IN_W+$clog2(LANES) bits
module mac_adder_tree #(
    parameter int LANES = 4,
    parameter int IN_W  = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic [LANES*IN_W-1:0]                    in_data,
    output logic signed [IN_W+$clog2(LANES)-1:0]     sum
);

    localparam int OUT_W = IN_W + $clog2(LANES);

    logic signed [OUT_W-1:0] sum_c;

    // The extra $clog2(LANES) bits absorb every possible carry, so the sum is exact.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c = sum_c + OUT_W'($signed(in_data[i*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_c;
        end
    end

endmodule

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: multi-lane fixed-point dot-product accumulator.
// S1 registers the LANES products, S2 reduces them, S3 accumulates with
// saturation across a vector of beats ending with last_in.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   valid_in / in_ready  input beat handshake
//   last_in              final beat of the vector
//   mode_in, C_in        seed select (0: C_in, 1: zero) and seed, first beat only
//   TA_in, TB_in         packed signed operand lanes
//   res_out, res_beats,
//   error_flag           result, beat count, saturation flag (S3 registers)
//   res_valid/res_ready  result handshake; result held until accepted
//   load_valid           pulse the cycle after a first beat is accepted
//   store_valid          res_valid & res_ready
module mac_dot_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    output logic                       in_ready,
    input  logic                       last_in,
    input  logic                       mode_in,
    input  logic [ACC_W-1:0]           C_in,
    input  logic [LANES*DATA_W-1:0]    TA_in,
    input  logic [LANES*DATA_W-1:0]    TB_in,
    output logic [ACC_W-1:0]           res_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [LEN_W-1:0]           res_beats,
    output logic                       error_flag,
    output logic                       load_valid,
    output logic                       store_valid
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    logic stall;
    logic accept;
    logic first_pend;

    logic [LANES*PROD_W-1:0] prod_c;
    logic                    s1_v;
    s1_ctrl_t                s1_ctrl;
    logic [ACC_W-1:0]        s1_c;
    logic [LANES*PROD_W-1:0] s1_prod;

    logic                    s2_v;
    s1_ctrl_t                s2_ctrl;
    logic [ACC_W-1:0]        s2_c;
    logic signed [SUM_W-1:0] s2_sum;

    logic signed [ACC_W-1:0] acc;
    logic [LEN_W-1:0]        cnt;
    logic                    err;
    logic                    rv;

    logic signed [ACC_W-1:0] seed;
    sat_res_t                add_r;
    logic                    unused_hi;

    assign stall       = rv & ~res_ready;
    assign in_ready    = ~stall;
    assign accept      = valid_in & in_ready;
    assign store_valid = rv & res_ready;

    assign res_out    = acc;
    assign res_valid  = rv;
    assign res_beats  = cnt;
    assign error_flag = err;

    // Operands are widened before multiplying so the full product is kept.
    always_comb begin
        prod_c = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_c[i*PROD_W +: PROD_W] = PROD_W'($signed(TA_in[i*DATA_W +: DATA_W]))
                                       * PROD_W'($signed(TB_in[i*DATA_W +: DATA_W]));
        end
    end

    // The next accepted beat opens a vector after reset or after a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_pend <= 1'b1;
            load_valid <= 1'b0;
        end else begin
            load_valid <= accept & first_pend;
            if (accept) begin
                first_pend <= last_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_ctrl <= '0;
            s1_c    <= '0;
            s1_prod <= '0;
        end else if (!stall) begin
            s1_v <= accept;
            if (accept) begin
                s1_ctrl <= '{last: last_in, first: first_pend, mode: mode_in};
                s1_c    <= C_in;
                s1_prod <= prod_c;
            end
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stall & s1_v),
        .in_data (s1_prod),
        .sum     (s2_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_ctrl <= '0;
            s2_c    <= '0;
        end else if (!stall) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_ctrl <= s1_ctrl;
                s2_c    <= s1_c;
            end
        end
    end

    always_comb begin
        seed = acc;
        if (s2_ctrl.first) begin
            seed = s2_ctrl.mode ? '0 : $signed(s2_c);
        end
        add_r = sat_add(SAT_W'(seed), SAT_W'(s2_sum), ACC_W);
    end

    // Clamped value bits above ACC_W are pure sign copies.
    assign unused_hi = ^add_r.val[SAT_W-1:ACC_W];

    // A store and the next vector's first beat may land in the same cycle:
    // the result is consumed while S3 already absorbs the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
            rv  <= 1'b0;
        end else if (!stall) begin
            rv <= s2_v & s2_ctrl.last;
            if (s2_v) begin
                acc <= add_r.val[ACC_W-1:0];
                if (s2_ctrl.first) begin
                    err <= add_r.ovf;
                    cnt <= LEN_W'(1);
                end else begin
                    err <= err | add_r.ovf;
                    cnt <= (&cnt) ? cnt : cnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_pipe.sv
module tb_mac_dot_pipe;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int AW = 40;
    localparam int LW = 8;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
    localparam longint AMIN = -AMAX - 64'sd1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic             in_ready;
    logic             last_in = 1'b0;
    logic             mode_in = 1'b0;
    logic [AW-1:0]    C_in = '0;
    logic [LN*DW-1:0] TA_in = '0;
    logic [LN*DW-1:0] TB_in = '0;
    logic [AW-1:0]    res_out;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [LW-1:0]    res_beats;
    logic             error_flag;
    logic             load_valid;
    logic             store_valid;

    int n_cmp = 0;
    int n_bad = 0;

    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;

    typedef struct {
        longint res;
        int     beats;
        bit     err;
    } exp_t;

    exp_t   exp_q[$];
    int     n_expected = 0;
    int     n_store = 0;
    int     cur_n = 0;
    longint cur_acc = 0;
    bit     cur_err = 1'b0;
    bit     exp_load = 1'b0;
    bit     prev_stall = 1'b0;
    longint prev_res = 0;
    int     prev_beats = 0;
    bit     prev_err = 1'b0;

    mac_dot_pipe #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .in_ready    (in_ready),
        .last_in     (last_in),
        .mode_in     (mode_in),
        .C_in        (C_in),
        .TA_in       (TA_in),
        .TB_in       (TB_in),
        .res_out     (res_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_beats   (res_beats),
        .error_flag  (error_flag),
        .load_valid  (load_valid),
        .store_valid (store_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event, expected one", nm);
    endtask

    function automatic longint dot(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < LN; i++) begin
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic longint sres();
        return longint'($signed(res_out));
    endfunction

    // Reference model and per-cycle comparison. Inputs change just after the
    // rising edge, so values seen here are exactly what the next edge uses.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_expected -= exp_q.size();
            exp_q.delete();
            cur_n      = 0;
            exp_load   = 1'b0;
            prev_stall = 1'b0;
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_out", sres(), 0);
            chk("rst_res_beats", res_beats, 0);
            chk("rst_error_flag", error_flag, 0);
            chk("rst_load_valid", load_valid, 0);
            chk("rst_store_valid", store_valid, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            chk("in_ready", in_ready, !(res_valid && !res_ready));
            chk("store_valid", store_valid, res_valid && res_ready);
            chk("load_valid", load_valid, exp_load);
            if (prev_stall) begin
                chk("hold_res_valid", res_valid, 1);
                chk("hold_res_out", sres(), prev_res);
                chk("hold_res_beats", res_beats, prev_beats);
                chk("hold_error_flag", error_flag, prev_err);
            end
            if (res_valid && res_ready) begin
                n_store++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_out", sres(), e.res);
                    chk("res_beats", res_beats, e.beats);
                    chk("error_flag", error_flag, e.err);
                end
            end
            exp_load = 1'b0;
            if (valid_in && in_ready) begin
                if (cur_n == 0) begin
                    cur_acc  = mode_in ? 0 : longint'($signed(C_in));
                    cur_err  = 1'b0;
                    exp_load = 1'b1;
                end
                cur_acc += dot(TA_in, TB_in);
                if (cur_acc > AMAX) begin
                    cur_acc = AMAX;
                    cur_err = 1'b1;
                end else if (cur_acc < AMIN) begin
                    cur_acc = AMIN;
                    cur_err = 1'b1;
                end
                cur_n++;
                if (last_in) begin
                    exp_q.push_back('{res: cur_acc, beats: (cur_n > 255) ? 255 : cur_n, err: cur_err});
                    n_expected++;
                    cur_n = 0;
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_res   = sres();
            prev_beats = res_beats;
            prev_err   = error_flag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b,
                             input bit last, input bit mode, input longint c);
        bit got;
        int guard;
        valid_in = 1'b1;
        TA_in    = a;
        TB_in    = b;
        last_in  = last;
        mode_in  = mode;
        C_in     = c[AW-1:0];
        got      = 1'b0;
        guard    = 0;
        while (!got && guard < 200) begin
            @(negedge clk);
            got = in_ready;
            tick();
            guard++;
        end
        if (!got) fail("send_timeout");
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic send_vec(input int n, input bit mode, input longint c, input bit rnd,
                            input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (rnd) send_beat({$urandom, $urandom}, {$urandom, $urandom}, k == n - 1, mode, c);
            else     send_beat(a, b, k == n - 1, mode, c);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_res(input string nm);
        int k = 0;
        @(negedge clk);
        while (!res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!res_valid) fail(nm);
    endtask

    function automatic longint rand_c();
        return longint'($signed({$urandom, $urandom})) >>> 24;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset held with random inputs.
        repeat (4) begin
            valid_in = 1'($urandom);
            last_in  = 1'($urandom);
            mode_in  = 1'($urandom);
            TA_in    = {$urandom, $urandom};
            TB_in    = {$urandom, $urandom};
            C_in     = AW'(rand_c());
            tick();
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Single beat: 1*5 + 2*6 + 3*7 + 4*8 + 10 = 80, with latency.
        send_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0, 64'sd10);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 20);
        chk("single_latency", lat, 3);
        chk("single_res", sres(), 80);
        chk("single_beats", res_beats, 1);
        chk("single_err", error_flag, 0);
        tick();

        // Multi-beat, zero seed (C_in must be ignored): 3 * 4 * (1*2) = 24.
        send_vec(3, 1'b1, 64'sd12345, 1'b0, {4{16'd1}}, {4{16'd2}}, 1'b0);
        wait_res("multi_wait");
        chk("multi_res", sres(), 24);
        chk("multi_beats", res_beats, 3);
        tick();

        // Saturation: 128 beats of 2^32 reach 2^39 and clamp.
        send_vec(128, 1'b1, 64'sd0, 1'b0, {4{16'h8000}}, {4{16'h8000}}, 1'b0);
        wait_res("sat_wait");
        chk("sat_res", sres(), AMAX);
        chk("sat_err", error_flag, 1);
        chk("sat_beats", res_beats, 128);
        tick();
        send_vec(1, 1'b0, -64'sd5, 1'b0, {4{16'd1}}, {4{16'd1}}, 1'b0);
        wait_res("post_sat_wait");
        chk("post_sat_err", error_flag, 0);
        chk("post_sat_res", sres(), -1);
        tick();

        // Beat counter saturates at 255.
        send_vec(300, 1'b0, 64'sd7, 1'b0, {4{16'd1}}, {4{16'd0}}, 1'b0);
        wait_res("cnt_wait");
        chk("cnt_beats", res_beats, 255);
        chk("cnt_res", sres(), 7);
        tick();

        // Backpressure: two back-to-back vectors, result held for 5+ cycles.
        rdy_force = 1'b0;
        tick();
        tick();
        fork
            begin
                send_vec(2, 1'b0, 64'sd100, 1'b0, {4{16'd3}}, {4{16'd4}}, 1'b0);
                send_vec(3, 1'b1, 64'sd999, 1'b0, {4{16'd5}}, {4{16'hFFFE}}, 1'b0);
            end
            begin
                wait_res("bp_wait");
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold", sres(), 196);
                end
                @(posedge clk);
                rdy_force = 1'b1;
                @(negedge clk);
                tick();
            end
        join
        wait_res("bp2_wait");
        chk("bp2_res", sres(), -120);
        chk("bp2_beats", res_beats, 3);
        tick();

        // Reset mid-vector, then a fresh one-beat vector: 3*(1+2+3+4) = 30.
        send_vec(2, 1'b0, rand_c(), 1'b1, '0, '0, 1'b0);
        send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 64'sd0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_vec(1, 1'b1, 64'sd0, 1'b0, {4{16'd3}}, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        wait_res("rst_mid_wait");
        chk("rst_mid_res", sres(), 30);
        chk("rst_mid_beats", res_beats, 1);
        tick();

        // Randomized traffic with random backpressure.
        rdy_rand = 1'b1;
        for (int v = 0; v < 40; v++) begin
            send_vec($urandom_range(1, 6), 1'($urandom), rand_c(), 1'b1, '0, '0, 1'b1);
        end
        rdy_rand = 1'b0;
        repeat (30) tick();

        chk("store_count", n_store, n_expected);
        chk("pending_results", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
